// File: rtl/i2s_clk_seq_if.sv
// Control, configuration and divider-facing signals of the I2S clock sequencer.
// The master side is whoever drives start/stop/config and returns sclk from the divider.
interface i2s_clk_seq_if;
   logic       start;
   logic       stop;
   logic       cfg_wr;
   logic [5:0] cfg_N;
   logic       cfg_f32;
   logic       sclk;
   logic [5:0] div_N;
   logic       div_rst_;
   logic       gen_en;
   logic       frame_f32;
   logic       frame_start;
   logic       busy;
   logic       cfg_err;

   modport master (
      output start, stop, cfg_wr, cfg_N, cfg_f32, sclk,
      input  div_N, div_rst_, gen_en, frame_f32, frame_start, busy, cfg_err
   );

   modport slave (
      input  start, stop, cfg_wr, cfg_N, cfg_f32, sclk,
      output div_N, div_rst_, gen_en, frame_f32, frame_start, busy, cfg_err
   );
endinterface

// File: rtl/i2s_clk_seq.sv
// I2S clock sequencer: releases the sclk divider, waits out its warm-up edges,
// frames word-select generation and guards the divider with an sclk watchdog.
module i2s_clk_seq #(
   parameter int WARMUP_EDGES = 4,
   parameter int WDOG_CYCLES  = 128
) (
   input  logic         pclk,
   input  logic         rst_,
   i2s_clk_seq_if.slave bus
);
   localparam int WARM_W = $clog2(WARMUP_EDGES + 1);
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_EDGES - 1);
   localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
   localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WARM  = 3'd2,
      RUN   = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                sclk_q_r;
   logic [5:0]          n_sh_r;
   logic                f32_sh_r;
   logic [5:0]          n_pend_r;
   logic                f32_pend_r;
   logic                pend_r;
   logic [WARM_W-1:0]   warm_cnt_r;
   logic [5:0]          bit_cnt_r;
   logic [WDOG_W-1:0]   wdog_cnt_r;
   logic [5:0]          div_n_r;
   logic                div_rst_r;
   logic                gen_en_r;
   logic                frame_f32_r;
   logic                frame_start_r;
   logic                busy_r;
   logic                cfg_err_r;

   logic                rise_s;
   logic                active_s;
   logic                streaming_s;
   logic                streaming_nxt_s;
   logic                active_nxt_s;
   logic [5:0]          last_bit_s;
   logic                frame_end_s;
   logic                wdog_fire_s;
   logic                cfg_idle_s;
   logic                apply_pend_s;
   logic                start_err_s;

   assign rise_s          = bus.sclk & ~sclk_q_r;
   assign active_s        = (state_r == WARM) | (state_r == RUN) | (state_r == DRAIN);
   assign streaming_s     = (state_r == RUN) | (state_r == DRAIN);
   assign active_nxt_s    = (state_nxt_s == WARM) | (state_nxt_s == RUN) | (state_nxt_s == DRAIN);
   assign streaming_nxt_s = (state_nxt_s == RUN) | (state_nxt_s == DRAIN);
   assign last_bit_s      = frame_f32_r ? 6'd63 : 6'd31;
   assign frame_end_s     = streaming_s & rise_s & (bit_cnt_r == last_bit_s);
   // Only a quiet stretch can trip the watchdog; a rise always restarts the count.
   assign wdog_fire_s     = active_s & ~rise_s & (wdog_cnt_r == WDOG_LAST);
   assign cfg_idle_s      = bus.cfg_wr & (state_r == IDLE);

   // Next-state decode; stop outranks start in IDLE and outranks a pending reload in RUN.
   always_comb begin
      state_nxt_s  = state_r;
      apply_pend_s = 1'b0;
      start_err_s  = 1'b0;
      if (wdog_fire_s) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start && !bus.stop) begin
                  if (n_sh_r >= 6'd2) begin
                     state_nxt_s = LOAD;
                  end else begin
                     start_err_s = 1'b1;
                  end
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            LOAD: state_nxt_s = WARM;
            WARM: begin
               if (rise_s && (warm_cnt_r == WARM_LAST)) begin
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = WARM;
               end
            end
            RUN: begin
               if (bus.stop && frame_end_s) begin
                  state_nxt_s  = IDLE;
                  apply_pend_s = pend_r;
               end else if (bus.stop) begin
                  state_nxt_s = DRAIN;
               end else if (frame_end_s && pend_r) begin
                  state_nxt_s  = LOAD;
                  apply_pend_s = 1'b1;
               end else begin
                  state_nxt_s = RUN;
               end
            end
            DRAIN: begin
               if (frame_end_s) begin
                  state_nxt_s  = IDLE;
                  apply_pend_s = pend_r;
               end else begin
                  state_nxt_s = DRAIN;
               end
            end
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge pclk or negedge rst_) begin
      if (!rst_) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Previous sclk sample for rise detection.
   always_ff @(posedge pclk or negedge rst_) begin
      if (!rst_) begin
         sclk_q_r <= 1'b0;
      end else begin
         sclk_q_r <= bus.sclk;
      end
   end

   // Shadow/pending configuration and the sticky error flag.
   always_ff @(posedge pclk or negedge rst_) begin
      if (!rst_) begin
         n_sh_r     <= 6'd0;
         f32_sh_r   <= 1'b0;
         n_pend_r   <= 6'd0;
         f32_pend_r <= 1'b0;
         pend_r     <= 1'b0;
         cfg_err_r  <= 1'b0;
      end else begin
         if (cfg_idle_s) begin
            n_sh_r   <= bus.cfg_N;
            f32_sh_r <= bus.cfg_f32;
         end else if (apply_pend_s) begin
            n_sh_r   <= n_pend_r;
            f32_sh_r <= f32_pend_r;
         end
         // A write landing on the reload cycle stays pending for the next boundary.
         if (bus.cfg_wr && (state_r != IDLE)) begin
            n_pend_r   <= bus.cfg_N;
            f32_pend_r <= bus.cfg_f32;
            pend_r     <= 1'b1;
         end else if (apply_pend_s || cfg_idle_s) begin
            pend_r <= 1'b0;
         end
         if (cfg_idle_s && (bus.cfg_N >= 6'd2)) begin
            cfg_err_r <= 1'b0;
         end else if (start_err_s || wdog_fire_s) begin
            cfg_err_r <= 1'b1;
         end
      end
   end

   // Warm-up edge, frame bit and watchdog counters.
   always_ff @(posedge pclk or negedge rst_) begin
      if (!rst_) begin
         warm_cnt_r <= '0;
         bit_cnt_r  <= 6'd0;
         wdog_cnt_r <= '0;
      end else begin
         if (state_r != WARM) begin
            warm_cnt_r <= '0;
         end else if (rise_s) begin
            warm_cnt_r <= warm_cnt_r + WARM_ONE;
         end
         if (!streaming_s) begin
            bit_cnt_r <= 6'd0;
         end else if (rise_s) begin
            bit_cnt_r <= frame_end_s ? 6'd0 : bit_cnt_r + 6'd1;
         end
         if (!active_s || rise_s) begin
            wdog_cnt_r <= '0;
         end else begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_ONE;
         end
      end
   end

   // Registered outputs follow the state being entered.
   always_ff @(posedge pclk or negedge rst_) begin
      if (!rst_) begin
         div_n_r       <= 6'd0;
         frame_f32_r   <= 1'b0;
         div_rst_r     <= 1'b0;
         gen_en_r      <= 1'b0;
         busy_r        <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         if (state_r == LOAD) begin
            div_n_r     <= n_sh_r;
            frame_f32_r <= f32_sh_r;
         end
         div_rst_r     <= active_nxt_s;
         gen_en_r      <= streaming_nxt_s;
         busy_r        <= (state_nxt_s != IDLE);
         frame_start_r <= streaming_s & streaming_nxt_s & rise_s & (bit_cnt_r == 6'd0);
      end
   end

   assign bus.div_N       = div_n_r;
   assign bus.div_rst_    = div_rst_r;
   assign bus.gen_en      = gen_en_r;
   assign bus.frame_f32   = frame_f32_r;
   assign bus.frame_start = frame_start_r;
   assign bus.busy        = busy_r;
   assign bus.cfg_err     = cfg_err_r;
endmodule

// File: tb/tb_i2s_clk_seq.sv
// Bench for i2s_clk_seq: table vectors, directed multi-cycle sequences and a random
// run, all checked every cycle against an event-level reference model.
module tb_i2s_clk_seq;
   localparam int WARMUP = 4;
   localparam int WDOG   = 128;

   logic pclk;
   logic rst_;
   i2s_clk_seq_if bus ();

   i2s_clk_seq #(.WARMUP_EDGES(WARMUP), .WDOG_CYCLES(WDOG)) dut (
      .pclk (pclk),
      .rst_ (rst_),
      .bus  (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int errors = 0;
   int checks = 0;
   int tick = 0;
   int rise_cnt = 0;
   int last_rise_tick = 0;
   int ph = 0;
   bit hold = 1'b0;

   // Reference model: sequencer phase plus running counts of sclk rises.
   typedef enum int {M_OFF, M_PREP, M_WARMUP, M_PLAY, M_FINISH} mode_t;
   mode_t m_mode;
   int    m_sh_n, m_pn, m_warm, m_bits, m_quiet, e_dn;
   bit    m_sh_f, m_pf, m_pend, m_err, e_df, e_fs, m_prev_sclk;

   typedef struct {
      logic       cw;
      logic [5:0] cn;
      logic       cf;
      logic       st;
      logic       sp;
      logic       busy;
      logic       err;
      logic       drst;
      logic [5:0] dn;
   } vec_t;
   vec_t vt[9];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, tick, got, exp);
      end
   endtask

   function automatic bit live(input mode_t m);
      return (m == M_WARMUP) || (m == M_PLAY) || (m == M_FINISH);
   endfunction

   task automatic model_reset();
      m_mode = M_OFF; m_sh_n = 0; m_pn = 0; m_warm = 0; m_bits = 0; m_quiet = 0; e_dn = 0;
      m_sh_f = 1'b0; m_pf = 1'b0; m_pend = 1'b0; m_err = 1'b0; e_df = 1'b0; e_fs = 1'b0;
      m_prev_sclk = 1'b0; ph = 0;
   endtask

   task automatic model_step(input bit st, input bit sp, input bit cw, input int cn, input bit cf,
                             input bit sclk);
      bit    rise = sclk && !m_prev_sclk;
      int    len = e_df ? 64 : 32;
      bit    fend = 1'b0;
      bit    apply = 1'b0;
      mode_t nm = m_mode;
      e_fs = 1'b0;
      if (live(m_mode)) m_quiet = rise ? 0 : m_quiet + 1;
      else m_quiet = 0;
      if (live(m_mode) && m_quiet == WDOG) begin
         nm = M_OFF;
         m_err = 1'b1;
      end else begin
         case (m_mode)
            M_OFF: if (st && !sp) begin
               if (m_sh_n >= 2) nm = M_PREP;
               else m_err = 1'b1;
            end
            M_PREP: begin
               nm = M_WARMUP; e_dn = m_sh_n; e_df = m_sh_f; m_warm = 0;
            end
            M_WARMUP: if (rise) begin
               m_warm++;
               if (m_warm == WARMUP) begin nm = M_PLAY; m_bits = 0; end
            end
            M_PLAY, M_FINISH: begin
               if (rise) begin
                  e_fs = (m_bits % len == 0);
                  fend = (m_bits % len == len - 1);
                  m_bits++;
               end
               if (m_mode == M_FINISH) begin
                  if (fend) begin nm = M_OFF; apply = 1'b1; end
               end else if (sp) begin
                  nm = fend ? M_OFF : M_FINISH; apply = fend;
               end else if (fend && m_pend) begin
                  nm = M_PREP; apply = 1'b1;
               end
            end
            default: nm = M_OFF;
         endcase
      end
      if (apply && m_pend) begin m_sh_n = m_pn; m_sh_f = m_pf; m_pend = 1'b0; end
      if (cw) begin
         if (m_mode == M_OFF) begin
            m_sh_n = cn; m_sh_f = cf; m_pend = 1'b0;
            if (cn >= 2) m_err = 1'b0;
         end else begin
            m_pn = cn; m_pf = cf; m_pend = 1'b1;
         end
      end
      m_prev_sclk = sclk;
      m_mode = nm;
   endtask

   // Stand-in divider, driven from the model's view of div_rst_/div_N.
   task automatic drive_div();
      int n = (e_dn < 2) ? 2 : e_dn;
      bit nxt;
      if (!live(m_mode)) begin
         ph = 0; nxt = 1'b0;
      end else if (hold) begin
         nxt = bus.sclk;
      end else begin
         ph = (ph + 1) % n; nxt = (ph >= n / 2);
      end
      if (nxt && !bus.sclk) begin rise_cnt++; last_rise_tick = tick + 1; end
      bus.sclk = nxt;
   endtask

   task automatic cycle();
      drive_div();
      model_step(bus.start, bus.stop, bus.cfg_wr, int'(bus.cfg_N), bus.cfg_f32, bus.sclk);
      @(posedge pclk);
      #1;
      tick++;
      check("model", {20'd0, bus.busy, bus.gen_en, bus.div_rst_, bus.frame_f32, bus.frame_start,
                      bus.cfg_err, bus.div_N},
            {20'd0, m_mode != M_OFF, (m_mode == M_PLAY) || (m_mode == M_FINISH), live(m_mode),
             e_df, e_fs, m_err, 6'(e_dn)});
      bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_wr = 1'b0;
   endtask

   task automatic wait_gen(input bit level, input int budget, input string name);
      int n = 0;
      while (bus.gen_en != level && n < budget) begin cycle(); n++; end
      check(name, {31'd0, bus.gen_en}, {31'd0, level});
   endtask

   task automatic wait_fs(input int budget, input string name);
      int n = 0;
      while (!bus.frame_start && n < budget) begin cycle(); n++; end
      check(name, {31'd0, bus.frame_start}, 32'd1);
   endtask

   task automatic set_cfg(input int n, input bit f);
      bus.cfg_wr = 1'b1; bus.cfg_N = 6'(n); bus.cfg_f32 = f;
   endtask

   initial begin
      int t0, r0, held, n;
      rst_ = 1'b0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_N = 6'd0;
      bus.cfg_f32 = 1'b0; bus.sclk = 1'b0;
      model_reset();
      repeat (3) @(posedge pclk);
      #1;
      check("reset_state", {19'd0, bus.busy, bus.gen_en, bus.div_rst_, bus.frame_f32,
                            bus.frame_start, bus.cfg_err, bus.div_N}, 32'd0);
      rst_ = 1'b1;

      // IDLE configuration/start vectors, ending in LOAD then WARM with N=4, 32-bit words.
      vt[0] = '{1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
      vt[1] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0};
      vt[2] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
      vt[3] = '{1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0};
      vt[4] = '{1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
      vt[5] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
      vt[6] = '{1'b1, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
      vt[7] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
      vt[8] = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd4};
      for (int i = 0; i < 9; i++) begin
         bus.cfg_wr = vt[i].cw; bus.cfg_N = vt[i].cn; bus.cfg_f32 = vt[i].cf;
         bus.start = vt[i].st; bus.stop = vt[i].sp;
         cycle();
         check($sformatf("vec%0d", i), {23'd0, bus.busy, bus.cfg_err, bus.div_rst_, bus.div_N},
               {23'd0, vt[i].busy, vt[i].err, vt[i].drst, vt[i].dn});
      end

      // Warm-up edge count and 64-bit frame spacing at N=4.
      r0 = rise_cnt;
      wait_gen(1'b1, 200, "gen_en_rise");
      check("warm_edges", rise_cnt - r0, WARMUP);
      t0 = tick;
      wait_fs(100, "first_fs");
      check("first_fs_delay", tick - t0, 32'd4);
      check("frame_f32_on", {31'd0, bus.frame_f32}, 32'd1);
      for (int k = 0; k < 2; k++) begin
         t0 = tick;
         cycle();
         check("fs_width", {31'd0, bus.frame_start}, 32'd0);
         wait_fs(400, "fs_next");
         check("fs_period64", tick - t0, 32'd256);
      end

      // Reconfigure while running: reload at the frame boundary.
      set_cfg(8, 1'b0);
      cycle();
      wait_gen(1'b0, 400, "gen_en_drop_reload");
      check("load_state", {30'd0, bus.busy, bus.div_rst_}, 32'd2);
      cycle();
      check("reload_cfg", {24'd0, bus.div_N, bus.frame_f32, bus.div_rst_}, {24'd0, 6'd8, 1'b0, 1'b1});
      r0 = rise_cnt;
      wait_gen(1'b1, 300, "gen_en_rerise");
      check("warm_edges2", rise_cnt - r0, WARMUP);
      wait_fs(100, "fs_after_reload");
      t0 = tick;
      cycle();
      wait_fs(400, "fs_next32");
      check("fs_period32", tick - t0, 32'd256);

      // N=6 16-bit words, stop at bit 10 drains to the end of the frame.
      set_cfg(6, 1'b0);
      cycle();
      wait_gen(1'b0, 400, "gen_en_drop6");
      wait_gen(1'b1, 300, "gen_en_rise6");
      wait_fs(100, "fs6");
      r0 = rise_cnt;
      n = 0;
      while (rise_cnt < r0 + 9 && n < 100) begin cycle(); n++; end
      r0 = rise_cnt;
      held = 1;
      bus.stop = 1'b1;
      n = 0;
      do begin
         cycle(); n++;
         if (bus.busy && !bus.gen_en) held = 0;
      end while (bus.busy && n < 400);
      check("drain_edges", rise_cnt - r0, 32'd22);
      check("gen_en_held", held, 32'd1);
      check("idle_after_drain", {30'd0, bus.busy, bus.gen_en}, 32'd0);

      // Watchdog: freeze sclk while running.
      bus.start = 1'b1;
      cycle();
      wait_gen(1'b1, 300, "gen_en_wdog");
      repeat (10) cycle();
      hold = 1'b1;
      n = 0;
      while (bus.busy && n < 300) begin cycle(); n++; end
      check("wdog_delay", tick - last_rise_tick, WDOG);
      check("wdog_state", {29'd0, bus.cfg_err, bus.div_rst_, bus.busy}, 32'd4);
      hold = 1'b0;

      // Error clears on a valid IDLE write; then asynchronous reset mid-run.
      set_cfg(2, 1'b1);
      cycle();
      check("err_clear", {31'd0, bus.cfg_err}, 32'd0);
      bus.start = 1'b1;
      cycle();
      wait_gen(1'b1, 100, "gen_en_pre_reset");
      repeat (20) cycle();
      rst_ = 1'b0;
      #1;
      check("reset_async", {19'd0, bus.busy, bus.gen_en, bus.div_rst_, bus.frame_f32,
                            bus.frame_start, bus.cfg_err, bus.div_N}, 32'd0);
      model_reset();
      #1;
      rst_ = 1'b1;

      // Random traffic against the model.
      n = 0;
      for (int i = 0; i < 5000; i++) begin
         int r = $urandom_range(0, 99);
         if (m_mode == M_OFF) begin
            if (r < 10) set_cfg($urandom_range(0, 9), 1'($urandom_range(0, 1)));
            else if (r < 18) bus.start = 1'b1;
            else if (r < 21) begin bus.start = 1'b1; bus.stop = 1'b1; end
            else if (r < 23) bus.stop = 1'b1;
         end else begin
            if (r < 2) set_cfg($urandom_range(0, 9), 1'($urandom_range(0, 1)));
            else if (r < 3 && (m_mode == M_PLAY || m_mode == M_FINISH)) bus.stop = 1'b1;
            else if (r < 5 && (m_mode == M_PLAY || m_mode == M_FINISH)) bus.start = 1'b1;
         end
         if (n > 0) begin
            n--; hold = (n > 0);
         end else if (m_mode != M_OFF && $urandom_range(0, 399) == 0) begin
            hold = 1'b1; n = $urandom_range(60, 200);
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/i2s_clk_seq.md
I2S_CLK_SEQ -- requirements
Module: i2s_clk_seq

Interface
REQ-001 Parameter WARMUP_EDGES, default 4: number of sclk rising edges waited after divider release before word-select generation starts.
REQ-002 Parameter WDOG_CYCLES, default 128: maximum pclk cycles allowed between sclk rising edges while the divider is active.
REQ-003 pclk  in  1  system clock; all state changes on posedge pclk.
REQ-004 rst_  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle request to begin clock/ws generation.
REQ-006 stop  in  1  single-cycle request to end generation at the next frame boundary.
REQ-007 cfg_wr  in  1  single-cycle strobe; cfg_N and cfg_f32 are valid on this cycle.
REQ-008 cfg_N  in  6  divider ratio pclk:sclk.
REQ-009 cfg_f32  in  1  frame size: 1 = 32-bit words, 0 = 16-bit words.
REQ-010 sclk  in  1  serial clock returned from the divider, synchronous to pclk.
REQ-011 div_N  out  6  ratio driven to the divider.
REQ-012 div_rst_  out  1  active-low hold for the divider.
REQ-013 gen_en  out  1  enable for the ws generator and tracker.
REQ-014 frame_f32  out  1  active frame size driven to the ws generator.
REQ-015 frame_start  out  1  single-pclk pulse at the start of each stereo frame.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 cfg_err  out  1  sticky configuration or watchdog error.

Function
REQ-018 sclk rise SHALL be detected as sclk & ~sclk_q, where sclk_q is sclk registered on pclk.
REQ-019 Shadow config (N_sh, f32_sh) SHALL load on cfg_wr in IDLE; in any other state cfg_wr SHALL store into a pending register and set pend.
REQ-020 Config is valid only when N_sh >= 2.
REQ-021 States SHALL be IDLE, LOAD, WARM, RUN, DRAIN.
REQ-022 IDLE: div_rst_=0, gen_en=0; on start with valid config -> LOAD.
REQ-023 IDLE: on start with N_sh < 2 -> stay in IDLE and set cfg_err.
REQ-024 IDLE: start and stop in the same cycle -> stop wins; stay in IDLE, no error.
REQ-025 LOAD lasts exactly 1 cycle: div_N <= N_sh, frame_f32 <= f32_sh, warm counter cleared, div_rst_ stays 0; -> WARM.
REQ-026 WARM: div_rst_=1, gen_en=0; count sclk rises; on the WARMUP_EDGES-th rise -> RUN with the bit counter at 0.
REQ-027 RUN: div_rst_=1, gen_en=1; the 6-bit bit counter increments on each sclk rise.
REQ-028 Frame length L SHALL be 64 if frame_f32=1, else 32; the counter wraps from L-1 to 0.
REQ-029 frame_start SHALL pulse on the cycle the counter leaves 0, i.e. on the first sclk rise of each frame, including the first frame after WARM.
REQ-030 Frame end is the sclk rise where counter = L-1.
REQ-031 RUN: stop -> DRAIN; start in RUN or DRAIN is ignored.
REQ-032 RUN: at frame end with pend=1 -> copy pending into shadow, clear pend, -> LOAD; gen_en drops in that same cycle.
REQ-033 DRAIN: behaves as RUN; at frame end -> IDLE, and pending is applied to shadow if pend=1.
REQ-034 Stop and frame end in the same cycle while in RUN -> IDLE directly.
REQ-035 Watchdog: in WARM, RUN or DRAIN, the pclk count since the last sclk rise reaching WDOG_CYCLES SHALL force IDLE and set cfg_err.
REQ-036 cfg_err SHALL clear only on a cfg_wr accepted in IDLE with cfg_N >= 2.
REQ-037 frame_start SHALL never assert outside RUN and DRAIN.

Reset
REQ-038 While rst_=0: state=IDLE, div_N=0, div_rst_=0, gen_en=0, frame_f32=0, frame_start=0, busy=0, cfg_err=0, pend=0, N_sh=0, f32_sh=0, all counters 0.
REQ-039 Reset asserted mid-frame SHALL take effect immediately (asynchronously) with no drain.

Verification
REQ-040 cfg_wr N=4, f32=1, then start -> div_rst_ rises 2 cycles later; gen_en rises on the 4th sclk rise; frame_start pulses every 64 sclk periods (256 pclk).
REQ-041 N=6, f16 running; stop at bit 10 -> gen_en stays high until the sclk rise at bit 31, then IDLE with busy=0.
REQ-042 cfg_wr N=1, then start -> stays IDLE, cfg_err=1; cfg_wr N=2 -> cfg_err=0.
REQ-043 In RUN N=4, cfg_wr N=8, f32=0 -> at frame end: LOAD, then div_N=8, frame_f32=0, WARM of 4 edges, then RUN with 32-bit frames.
REQ-044 In RUN, hold sclk constant -> 128 pclk later: IDLE, cfg_err=1, div_rst_=0.
REQ-045 Start and stop together in IDLE -> no state change; assert rst_=0 mid-RUN -> all outputs at reset values in the same cycle.
